// File: rtl/ins_decode_unit_pkg.sv
// Shared decode definitions: default widths, opcode table, instruction field positions,
// the issued packet layout and the per-opcode operand/writeback classification.
package decode_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int BUS_WIDTH  = 32;
    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;

    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_I      = 6'h01;
    localparam logic [5:0] OP_LOAD   = 6'h02;
    localparam logic [5:0] OP_STORE  = 6'h03;
    localparam logic [5:0] OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_JUMP   = 6'h05;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 21;
    localparam int RS1_MSB    = 20;
    localparam int RS1_LSB    = 16;
    localparam int RS2_MSB    = 15;
    localparam int RS2_LSB    = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int IMM_WIDTH  = IMM_MSB - IMM_LSB + 1;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic legal;
    } op_info_t;

    typedef struct packed {
        logic [5:0]            opcode;
        logic [ADDR_WIDTH-1:0] rd;
        logic [REG_WIDTH-1:0]  op_a;
        logic [REG_WIDTH-1:0]  op_b;
        logic [REG_WIDTH-1:0]  imm;
        logic [BUS_WIDTH-1:0]  npc;
        logic                  writes_rd;
        logic                  illegal;
    } ex_packet_t;

    function automatic op_info_t op_info(input logic [5:0] opcode);
        op_info_t info;
        case (opcode)
            OP_R:               info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1, legal: 1'b1};
            OP_I, OP_LOAD:      info = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, legal: 1'b1};
            OP_STORE, OP_BRANCH: info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, legal: 1'b1};
            OP_JUMP, OP_HALT:   info = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, legal: 1'b1};
            default:            info = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, legal: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ins_decode_unit_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set at issue,
// cleared by writeback or by flushing an unconsumed writer. Register 0 is never busy.
module reg_scoreboard #(
    parameter int reg_count  = 32,
    parameter int addr_width = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [addr_width-1:0] set_addr,
    input  logic                  clr_a_en,
    input  logic [addr_width-1:0] clr_a_addr,
    input  logic                  clr_b_en,
    input  logic [addr_width-1:0] clr_b_addr,
    output logic [reg_count-1:0]  busy_out
);

    logic [reg_count-1:0] busy_q;
    logic [reg_count-1:0] busy_d;

    // NOTE: combinational blocks use blocking '=' with a full default first, so no
    // latch is inferred and later statements deliberately override earlier ones.
    always_comb begin
        busy_d = busy_q;
        if (clr_a_en) begin
            busy_d[clr_a_addr] = 1'b0;
        end
        if (clr_b_en) begin
            busy_d[clr_b_addr] = 1'b0;
        end
        // Set is applied last so it wins over a same-cycle clear of the same register.
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_out = busy_q;

endmodule

// File: rtl/ins_decode_unit.sv
// Decode stage: holds one fetched instruction (D slot), reads operands, blocks RAW
// hazards via the scoreboard and issues a packet (E slot) over valid/ready.
module ins_decode_unit
    import decode_pkg::*;
#(
    parameter int reg_width  = REG_WIDTH,
    parameter int bus_width  = BUS_WIDTH,
    parameter int reg_count  = REG_COUNT,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [bus_width-1:0]  ins_in,
    input  logic [bus_width-1:0]  npc_in,
    input  logic                  ins_valid_in,
    input  logic                  flush_in,
    output logic [addr_width-1:0] rs1_addr_out,
    output logic [addr_width-1:0] rs2_addr_out,
    input  logic [reg_width-1:0]  rs1_data_in,
    input  logic [reg_width-1:0]  rs2_data_in,
    input  logic                  wb_valid_in,
    input  logic [addr_width-1:0] wb_addr_in,
    input  logic                  ex_ready_in,
    output logic                  ex_valid_out,
    output logic [5:0]            opcode_out,
    output logic [addr_width-1:0] rd_out,
    output logic [reg_width-1:0]  op_a_out,
    output logic [reg_width-1:0]  op_b_out,
    output logic [reg_width-1:0]  imm_out,
    output logic [bus_width-1:0]  npc_out,
    output logic                  illegal_out,
    output logic                  freeze_out
);

    logic                  d_valid_q, d_valid_d;
    logic [bus_width-1:0]  d_ins_q,   d_ins_d;
    logic [bus_width-1:0]  d_npc_q,   d_npc_d;
    logic                  e_valid_q, e_valid_d;
    ex_packet_t            e_pkt_q,   e_pkt_d;

    logic [5:0]            d_opcode;
    logic [addr_width-1:0] d_rd;
    logic [addr_width-1:0] d_rs1;
    logic [addr_width-1:0] d_rs2;
    op_info_t              d_info;
    logic [reg_count-1:0]  sb_busy;
    logic                  hazard;
    logic                  issue;
    logic                  freeze;
    logic                  accept;
    logic                  sb_set_en;
    logic                  flush_clr_en;
    ex_packet_t            issue_pkt;

    always_comb begin
        d_opcode = d_ins_q[OPCODE_MSB:OPCODE_LSB];
        d_rd     = d_ins_q[RD_MSB:RD_LSB];
        d_rs1    = d_ins_q[RS1_MSB:RS1_LSB];
        d_rs2    = d_ins_q[RS2_MSB:RS2_LSB];
        d_info   = op_info(d_opcode);
    end

    // Hazard uses the registered scoreboard only: a writeback is seen one cycle later.
    always_comb begin
        hazard = (d_info.uses_rs1 && (d_rs1 != '0) && sb_busy[d_rs1])
              || (d_info.uses_rs2 && (d_rs2 != '0) && sb_busy[d_rs2]);
        issue  = d_valid_q && !hazard && (!e_valid_q || ex_ready_in) && !flush_in;
        freeze = d_valid_q && !issue && !flush_in;
        accept = ins_valid_in && !freeze && !flush_in;
    end

    // Operands an opcode does not read are issued as zero rather than stale port data.
    always_comb begin
        issue_pkt.opcode    = d_opcode;
        issue_pkt.rd        = d_rd;
        issue_pkt.op_a      = d_info.uses_rs1 ? rs1_data_in : '0;
        issue_pkt.op_b      = d_info.uses_rs2 ? rs2_data_in : '0;
        issue_pkt.imm       = {{(reg_width - IMM_WIDTH){d_ins_q[IMM_MSB]}}, d_ins_q[IMM_MSB:IMM_LSB]};
        issue_pkt.npc       = d_npc_q;
        issue_pkt.writes_rd = d_info.writes_rd;
        issue_pkt.illegal   = !d_info.legal;
    end

    always_comb begin
        d_valid_d = d_valid_q;
        d_ins_d   = d_ins_q;
        d_npc_d   = d_npc_q;
        if (flush_in) begin
            d_valid_d = 1'b0;
        end else if (accept) begin
            d_valid_d = 1'b1;
            d_ins_d   = ins_in;
            d_npc_d   = npc_in;
        end else if (issue) begin
            d_valid_d = 1'b0;
        end
    end

    always_comb begin
        e_valid_d = e_valid_q;
        e_pkt_d   = e_pkt_q;
        if (flush_in) begin
            e_valid_d = 1'b0;
        end else if (issue) begin
            e_valid_d = 1'b1;
            e_pkt_d   = issue_pkt;
        end else if (ex_ready_in) begin
            e_valid_d = 1'b0;
        end
    end

    // A flushed writer that execute never took will never write back, so release its bit.
    always_comb begin
        sb_set_en    = issue && d_info.writes_rd && (d_rd != '0);
        flush_clr_en = flush_in && e_valid_q && !ex_ready_in && e_pkt_q.writes_rd;
    end

    // NOTE: payload registers are reset as well as the valid bits, so every output
    // reads zero as soon as reset asserts, without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_valid_q <= 1'b0;
            d_ins_q   <= '0;
            d_npc_q   <= '0;
            e_valid_q <= 1'b0;
            e_pkt_q   <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_ins_q   <= d_ins_d;
            d_npc_q   <= d_npc_d;
            e_valid_q <= e_valid_d;
            e_pkt_q   <= e_pkt_d;
        end
    end

    reg_scoreboard #(
        .reg_count  (reg_count),
        .addr_width (addr_width)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (sb_set_en),
        .set_addr   (d_rd),
        .clr_a_en   (wb_valid_in),
        .clr_a_addr (wb_addr_in),
        .clr_b_en   (flush_clr_en),
        .clr_b_addr (e_pkt_q.rd),
        .busy_out   (sb_busy)
    );

    assign rs1_addr_out = d_rs1;
    assign rs2_addr_out = d_rs2;
    assign ex_valid_out = e_valid_q;
    assign opcode_out   = e_pkt_q.opcode;
    assign rd_out       = e_pkt_q.rd;
    assign op_a_out     = e_pkt_q.op_a;
    assign op_b_out     = e_pkt_q.op_b;
    assign imm_out      = e_pkt_q.imm;
    assign npc_out      = e_pkt_q.npc;
    assign illegal_out  = e_pkt_q.illegal;
    assign freeze_out   = freeze;

endmodule

// File: doc/ins_decode_unit.md
Name: ins_decode_unit

Overview:
- Second pipeline stage, directly downstream of the instruction fetch unit.
- Accepts the fetched instruction and its next-PC, and decodes the fields.
- Reads source operands from the external register file and blocks RAW hazards with a per-register pending-write scoreboard.
- Issues a decoded packet to the execute stage over a valid/ready handshake, and freezes fetch while it cannot accept.

Parameters:
- reg_width, 32, operand/data width
- bus_width, 32, instruction and PC width
- reg_count, 32, architectural registers
- addr_width, 5, register index width (log2 reg_count)

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- ins_in  in  bus_width  instruction from fetch
- npc_in  in  bus_width  next-PC from fetch
- ins_valid_in  in  1  ins_in/npc_in valid this cycle
- flush_in  in  1  taken jump/branch resolved; kill all held instructions
- rs1_addr_out  out  addr_width  register file read port 1 address
- rs2_addr_out  out  addr_width  read port 2 address
- rs1_data_in  in  reg_width  combinational read data, port 1
- rs2_data_in  in  reg_width  combinational read data, port 2
- wb_valid_in  in  1  writeback retiring a register write
- wb_addr_in  in  addr_width  register being written back
- ex_ready_in  in  1  execute stage can take a packet
- ex_valid_out  out  1  packet valid
- opcode_out  out  6  ins[31:26]
- rd_out  out  addr_width  ins[25:21]
- op_a_out, op_b_out  out  reg_width  operand values
- imm_out  out  reg_width  sign-extended ins[15:0]
- npc_out  out  bus_width  forwarded next-PC
- illegal_out  out  1  opcode not in package table
- freeze_out  out  1  to fetch freeze_in; fetch must hold its instruction

Behaviour:
- Fields: rs1=ins[20:16], rs2=ins[15:11]. Opcode classes come from the package:
  - R-type: reads rs1, rs2; writes rd.
  - I-type and LOAD: read rs1; write rd.
  - STORE and BRANCH: read rs1, rs2.
  - JUMP: no reads.
  - HALT and unknown opcodes: no reads, no write. Unknown sets illegal_out.
- Two registers:
  - D slot: accepted instruction plus npc.
  - E slot: issued packet, including the writes-rd flag.
- Reset: both slots invalid, scoreboard all 0. All outputs are 0, so ex_valid_out=0 and freeze_out=0.
- Accept: the D slot loads on a posedge when ins_valid_in=1, freeze_out=0 and flush_in=0.
- Read: the rs addresses are driven from the D slot. Data is sampled into the E slot at issue.
- Hazard: a used source register rsX!=0 with scoreboard[rsX]=1. Register 0 never hazards.
- Issue: occurs when D is valid, there is no hazard, and (E is empty or ex_ready_in=1). On issue, E loads the packet and, if the instruction writes rd!=0, scoreboard[rd] is set.
- E drain: when ex_valid_out=1 and ex_ready_in=1 with no new issue, E becomes invalid.
- Latency: accepted at edge N, ex_valid_out=1 after edge N+1 when hazard-free and execute is ready. Throughput is 1 per cycle.
- freeze_out is combinational: D valid AND NOT issue.
- Writeback: wb_valid_in clears scoreboard[wb_addr_in] at the edge. The hazard is re-evaluated the next cycle, so there is no same-cycle bypass. If a set and a clear of the same register occur in the same cycle, the set wins.
- Flush: D and E are invalidated at the edge. If E holds an unconsumed rd-writer (ex_ready_in=0), its scoreboard bit is cleared. Flush has priority over accept, issue and set. freeze_out is 0 during the flush cycle.
- Reset mid-operation discards everything; no packet completes.
- The E output holds stable while ex_valid_out=1 and ex_ready_in=0.

Decomposition:
- Package DECODE_PKG holds:
  - Opcode constants: R=6'h00, I=6'h01, LOAD=6'h02, STORE=6'h03, BRANCH=6'h04, JUMP=6'h05, HALT=6'h3F.
  - The field bit positions.
  - A packed struct for the E packet.
  - A function returning {uses_rs1, uses_rs2, writes_rd, legal} per opcode.
- One sub-module: reg_scoreboard (set/clear/query bit vector, reg_count bits, set-wins rule).

Test Plan:
- Reset mid-stream: reset high with D and E valid. All outputs are 0 immediately and the scoreboard is 0, with no clock edge needed.
- Back-to-back independent ops: R r3=r1+r2, then I r4=r5+imm 0xFFFF. Both issue on consecutive cycles with no freeze. imm_out=0xFFFFFFFF.
- RAW stall: R r3=r1+r2 followed by R r6=r3+r1. freeze_out=1 until a cycle after wb_valid_in with addr 3, then the second op issues with op_a=rs1_data.
- Backpressure: ex_ready_in=0 for 3 cycles. The E packet holds stable, a second instruction waits in D, and freeze_out rises once D is full.
- Flush: flush_in with an unconsumed E rd=7 writer. Both slots are invalid the next cycle and scoreboard[7]=0. A following read of r7 issues without stall.
- Illegal/zero regs: opcode 0x2A gives illegal_out=1 and no scoreboard change. R r0=r0+r0 gives no stall and scoreboard[0] stays 0.
